// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one synchronous FIFO write port
// between N_REQ producers; aborts a burst that stalls on a full FIFO too long.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DW          = 8,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ-1:0]    req_last,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_din,
  output logic                stall_abort,
  output logic [15:0]         beats_total
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_owner_n;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_n;
  logic [CW-1:0]   r_beat_cnt;
  logic [CW-1:0]   w_beat_cnt_n;
  logic [CW-1:0]   r_stall_cnt;
  logic [CW-1:0]   w_stall_cnt_n;
  logic            r_stall_abort;
  logic            w_abort_n;
  logic [TW-1:0]   r_beats_total;
  logic [TW-1:0]   w_total_n;

  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic [DW-1:0]   w_slice;
  logic            w_beat;
  logic            w_release;
  logic [CW-1:0]   w_beat_cnt_inc;
  logic [CW-1:0]   w_stall_cnt_inc;

  assign gnt             = r_gnt;
  assign stall_abort     = r_stall_abort;
  assign beats_total     = r_beats_total;
  assign w_beat_cnt_inc  = r_beat_cnt + CW'(1);
  assign w_stall_cnt_inc = r_stall_cnt + CW'(1);

  // Round-robin scan starting just after the last owner, wrapping at N_REQ.
  always_comb begin : arb_pick
    int unsigned idx;
    w_pick  = r_owner;
    w_found = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(r_owner) + k) % N_REQ;
      if (!w_found && req[IW'(idx)]) begin
        w_found = 1'b1;
        w_pick  = IW'(idx);
      end
    end
  end

  // Owner's data slice selected with constant part-selects.
  always_comb begin : owner_slice
    w_slice = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IW'(i) == r_owner) begin
        w_slice = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin : next_state
    w_state_n     = r_state;
    w_owner_n     = r_owner;
    w_gnt_n       = r_gnt;
    w_beat_cnt_n  = r_beat_cnt;
    w_stall_cnt_n = r_stall_cnt;
    w_abort_n     = 1'b0;
    w_total_n     = r_beats_total;
    w_release     = 1'b0;
    w_beat        = 1'b0;
    ack           = '0;
    fifo_wr_en    = 1'b0;
    fifo_din      = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_owner_n = w_pick;
          w_gnt_n   = N_REQ'(1) << w_pick;
          w_state_n = ST_BURST;
        end
      end

      ST_BURST: begin
        w_beat = req[r_owner] & ~fifo_full;
        if (w_beat) begin
          fifo_wr_en    = 1'b1;
          fifo_din      = w_slice;
          ack[r_owner]  = 1'b1;
          w_beat_cnt_n  = w_beat_cnt_inc;
          w_total_n     = r_beats_total + TW'(1);
          w_stall_cnt_n = '0;
          if (req_last[r_owner] || (w_beat_cnt_inc == CW'(MAX_BURST))) begin
            w_release = 1'b1;
          end
        end else if (!req[r_owner]) begin
          w_release = 1'b1;
        end else if (w_stall_cnt_inc == CW'(STALL_LIMIT)) begin
          // Owner stuck behind a full FIFO: give the port to someone else.
          w_release = 1'b1;
          w_abort_n = 1'b1;
        end else begin
          w_stall_cnt_n = w_stall_cnt_inc;
        end

        if (w_release) begin
          w_state_n     = ST_IDLE;
          w_gnt_n       = '0;
          w_beat_cnt_n  = '0;
          w_stall_cnt_n = '0;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
        w_gnt_n   = '0;
      end
    endcase
  end

  // r_owner doubles as the last-owner pointer while idle.
  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= IW'(N_REQ - 1);
      r_gnt         <= '0;
      r_beat_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_stall_abort <= 1'b0;
      r_beats_total <= '0;
    end else begin
      r_state       <= w_state_n;
      r_owner       <= w_owner_n;
      r_gnt         <= w_gnt_n;
      r_beat_cnt    <= w_beat_cnt_n;
      r_stall_cnt   <= w_stall_cnt_n;
      r_stall_abort <= w_abort_n;
      r_beats_total <= w_total_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producers emit an incrementing per-producer
// data pattern and a FIFO model records every accepted beat.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        stall_abort;
  logic [15:0] beats_total;

  logic [7:0]  prod_cnt [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0]  sb [$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          idx0;
  int          cyc;

  fifo_wr_arbiter #(
    .N_REQ(4), .DW(8), .MAX_BURST(8), .STALL_LIMIT(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .ack(ack), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .stall_abort(stall_abort), .beats_total(beats_total)
  );

  always #5 clk = ~clk;

  // Producer i offers i*64 + (beats of i accepted so far).
  always_comb begin
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i*64) + prod_cnt[i];
  end

  // FIFO model and producer advance on accepted beats.
  always @(posedge clk) begin
    if (fifo_wr_en) sb.push_back(fifo_din);
    for (int i = 0; i < 4; i++) if (ack[i]) prod_cnt[i] <= prod_cnt[i] + 8'd1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_last = '0; fifo_full = 1'b0;
    tick; tick;
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_total", 32'(beats_total), 32'h0);
    chk("rst_abort", 32'(stall_abort), 32'h0);
    rst = 1'b0;
    settle;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);

    // Four-way contention, no last, FIFO never full: 0,1,2,3,0 each 8 beats.
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      settle;
      chk("t1_idle_gnt", 32'(gnt), 32'h0);
      chk("t1_idle_wr",  32'(fifo_wr_en), 32'h0);
      if (b == 4) chk("t1_total32", 32'(beats_total), 32'd32);
      tick;
      for (int k = 0; k < 8; k++) begin
        chk("t1_gnt", 32'(gnt), 32'(1) << (b % 4));
        chk("t1_ack", 32'(ack), 32'(1) << (b % 4));
        chk("t1_din", 32'(fifo_din), 32'((b % 4) * 64 + (b / 4) * 8 + k));
        tick;
      end
    end
    req = 4'b0000;
    tick;
    chk("t1_total40", 32'(beats_total), 32'd40);

    // Single requester 2, last on third beat, two bursts.
    req = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      req_last = 4'b0000;
      settle;
      chk("t2_idle_gnt", 32'(gnt), 32'h0);
      tick;
      for (int k = 0; k < 3; k++) begin
        req_last = (k == 2) ? 4'b0100 : 4'b0000;
        settle;
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_ack", 32'(ack), 32'h4);
        chk("t2_din", 32'(fifo_din), 32'(128 + 8 + r * 3 + k));
        tick;
      end
    end
    req_last = 4'b0000;
    settle;
    chk("t2_end_gnt", 32'(gnt), 32'h0);
    chk("t2_total",   32'(beats_total), 32'd46);

    // Owner 1 stalls on full for 16 cycles -> abort, then 2 is granted.
    req = 4'b0110;
    settle;
    tick;
    for (int k = 0; k < 2; k++) begin
      settle;
      chk("t3_gnt", 32'(gnt), 32'h2);
      chk("t3_din", 32'(fifo_din), 32'(72 + k));
      tick;
    end
    fifo_full = 1'b1;
    for (int s = 0; s < 16; s++) begin
      settle;
      chk("t3_stall_gnt",   32'(gnt), 32'h2);
      chk("t3_stall_wr",    32'(fifo_wr_en), 32'h0);
      chk("t3_stall_ack",   32'(ack), 32'h0);
      chk("t3_stall_abort", 32'(stall_abort), 32'h0);
      tick;
    end
    fifo_full = 1'b0;
    settle;
    chk("t3_abort_pulse", 32'(stall_abort), 32'h1);
    chk("t3_abort_gnt",   32'(gnt), 32'h0);
    tick;
    chk("t3_abort_clear", 32'(stall_abort), 32'h0);
    chk("t3_regrant",     32'(gnt), 32'h4);

    // Owner 2: 3 beats, full for 5 cycles, 5 more beats; burst ends at 8.
    idx0 = sb.size();
    for (int k = 0; k < 3; k++) begin
      settle;
      chk("t4_ack", 32'(ack), 32'h4);
      chk("t4_din", 32'(fifo_din), 32'(142 + k));
      tick;
    end
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      settle;
      chk("t4_stall_gnt",   32'(gnt), 32'h4);
      chk("t4_stall_wr",    32'(fifo_wr_en), 32'h0);
      chk("t4_stall_abort", 32'(stall_abort), 32'h0);
      tick;
    end
    fifo_full = 1'b0;
    for (int k = 3; k < 8; k++) begin
      settle;
      chk("t4_ack2", 32'(ack), 32'h4);
      chk("t4_din2", 32'(fifo_din), 32'(142 + k));
      tick;
    end
    settle;
    chk("t4_end_gnt", 32'(gnt), 32'h0);
    chk("t4_total",   32'(beats_total), 32'd56);
    chk("t4_sb_count", 32'(sb.size() - idx0), 32'd8);
    for (int j = 0; j < 8; j++) chk("t4_sb_data", 32'(sb[idx0 + j]), 32'(142 + j));

    // Reset in the cycle of owner 3's fourth beat.
    req = 4'b1110;
    settle;
    tick;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) rst = 1'b1;
      settle;
      chk("t5_gnt", 32'(gnt), 32'h8);
      if (k < 3) chk("t5_din", 32'(fifo_din), 32'(200 + k));
      tick;
    end
    settle;
    chk("t5_rst_gnt",   32'(gnt), 32'h0);
    chk("t5_rst_wr",    32'(fifo_wr_en), 32'h0);
    chk("t5_rst_total", 32'(beats_total), 32'h0);
    rst = 1'b0;
    req = 4'b1111;
    settle;
    chk("t5_idle_wr", 32'(fifo_wr_en), 32'h0);
    tick;
    settle;
    chk("t5_first_gnt", 32'(gnt), 32'h1);
    chk("t5_first_din", 32'(fifo_din), 32'd16);
    tick;
    req = 4'b0000;
    settle;
    chk("t5_drop_wr", 32'(fifo_wr_en), 32'h0);
    tick;
    settle;
    chk("t5_drop_gnt", 32'(gnt), 32'h0);
    chk("t5_total1",   32'(beats_total), 32'd1);

    // Run beats_total up to 0xFFFF, then one more beat wraps it to 0.
    req = 4'b1111;
    cyc = 0;
    while (beats_total != 16'hFFFF && cyc < 80000) begin
      tick;
      cyc++;
    end
    chk("t6_total_ffff", 32'(beats_total), 32'hFFFF);
    cyc = 0;
    settle;
    while (!fifo_wr_en && cyc < 20) begin
      tick;
      settle;
      cyc++;
    end
    chk("t6_wr_beat", 32'(fifo_wr_en), 32'h1);
    tick;
    chk("t6_wrap", 32'(beats_total), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
